axil_reg_sequencer: RTL

AXIL_REG_SEQUENCER -- requirements
Module: axil_reg_sequencer

---
 rtl/axil_reg_sequencer_if.sv | 42 ++++
 rtl/axil_reg_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_sequencer_if.sv
// AXI4-Lite bus between the register sequencer (master) and a register slave.
interface axil_reg_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 4
);

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [2:0]            AWPROT;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [31:0]           WDATA;
  logic [3:0]            WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [31:0]           RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );

endinterface

// File: rtl/axil_reg_sequencer.sv
// Writes a block of 32-bit registers over AXI4-Lite, reads them all back,
// and reports whether every response was OKAY and every readback matched.
module axil_reg_sequencer #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     start,
  input  logic [32*NUM_REGS-1:0]   cfg_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [7:0]               err_index,
  axil_reg_sequencer_if.master     m_axi
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SHADOW_W = DATA_W * NUM_REGS;
  localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    FIN
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [SHADOW_W-1:0]   shadow, shadow_nxt;
  logic                  awvalid_q, awvalid_nxt;
  logic                  wvalid_q, wvalid_nxt;
  logic                  bready_q, bready_nxt;
  logic                  arvalid_q, arvalid_nxt;
  logic                  rready_q, rready_nxt;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_nxt;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_nxt;
  logic [DATA_W-1:0]     wdata_q, wdata_nxt;
  logic                  error_nxt;
  logic [7:0]            err_index_nxt;

  // Byte address of register k.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] k);
    return ADDR_WIDTH'(BASE_ADDR + (32'(k) << 2));
  endfunction

  // 32-bit word k of a packed register vector.
  function automatic logic [DATA_W-1:0] word_of(input logic [SHADOW_W-1:0] v,
                                                input logic [IDX_W-1:0]    k);
    return v[int'(k)*DATA_W +: DATA_W];
  endfunction

  assign m_axi.AWADDR  = awaddr_q;
  assign m_axi.AWPROT  = 3'b000;
  assign m_axi.AWVALID = awvalid_q;
  assign m_axi.WDATA   = wdata_q;
  assign m_axi.WSTRB   = 4'hF;
  assign m_axi.WVALID  = wvalid_q;
  assign m_axi.BREADY  = bready_q;
  assign m_axi.ARADDR  = araddr_q;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.RREADY  = rready_q;

  // Next-state and next-output decode; every flop holds unless a branch moves it.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    shadow_nxt    = shadow;
    awvalid_nxt   = awvalid_q;
    wvalid_nxt    = wvalid_q;
    bready_nxt    = bready_q;
    arvalid_nxt   = arvalid_q;
    rready_nxt    = rready_q;
    awaddr_nxt    = awaddr_q;
    araddr_nxt    = araddr_q;
    wdata_nxt     = wdata_q;
    error_nxt     = error;
    err_index_nxt = err_index;

    unique case (state)
      IDLE: begin
        if (start) begin
          shadow_nxt    = cfg_data;
          idx_nxt       = '0;
          error_nxt     = 1'b0;
          err_index_nxt = 8'h00;
          awvalid_nxt   = 1'b1;
          wvalid_nxt    = 1'b1;
          awaddr_nxt    = addr_of('0);
          wdata_nxt     = word_of(cfg_data, '0);
          state_nxt     = WR_REQ;
        end
      end

      WR_REQ: begin
        // A channel whose VALID is already low has completed its handshake.
        if (m_axi.AWREADY) awvalid_nxt = 1'b0;
        if (m_axi.WREADY)  wvalid_nxt  = 1'b0;
        if ((!awvalid_q || m_axi.AWREADY) && (!wvalid_q || m_axi.WREADY)) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_axi.BVALID) begin
          bready_nxt = 1'b0;
          if (m_axi.BRESP != 2'b00) begin
            error_nxt = 1'b1;
            if (!error) err_index_nxt = 8'(idx);
          end
          if (idx != LAST_IDX) begin
            idx_nxt     = idx + IDX_W'(1);
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            awaddr_nxt  = addr_of(idx + IDX_W'(1));
            wdata_nxt   = word_of(shadow, idx + IDX_W'(1));
            state_nxt   = WR_REQ;
          end else begin
            idx_nxt     = '0;
            arvalid_nxt = 1'b1;
            araddr_nxt  = addr_of('0);
            state_nxt   = RD_REQ;
          end
        end
      end

      RD_REQ: begin
        if (m_axi.ARREADY) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_RESP;
        end
      end

      RD_RESP: begin
        if (m_axi.RVALID) begin
          rready_nxt = 1'b0;
          if ((m_axi.RRESP != 2'b00) || (m_axi.RDATA != word_of(shadow, idx))) begin
            error_nxt = 1'b1;
            if (!error) err_index_nxt = 8'(idx);
          end
          if (idx != LAST_IDX) begin
            idx_nxt     = idx + IDX_W'(1);
            arvalid_nxt = 1'b1;
            araddr_nxt  = addr_of(idx + IDX_W'(1));
            state_nxt   = RD_REQ;
          end else begin
            state_nxt   = FIN;
          end
        end
      end

      FIN: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset clears everything at once.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      idx       <= '0;
      shadow    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= 8'h00;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      shadow    <= shadow_nxt;
      awvalid_q <= awvalid_nxt;
      wvalid_q  <= wvalid_nxt;
      bready_q  <= bready_nxt;
      arvalid_q <= arvalid_nxt;
      rready_q  <= rready_nxt;
      awaddr_q  <= awaddr_nxt;
      araddr_q  <= araddr_nxt;
      wdata_q   <= wdata_nxt;
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == FIN);
      error     <= error_nxt;
      err_index <= err_index_nxt;
    end
  end

endmodule
